data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter_if.sv | 25 ++
 rtl/data_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_data_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// Client-side command/response bundle for one data memory arbiter port.
// The master modport is the requester; the slave modport is the arbiter.
interface data_mem_arbiter_if;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic          req;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          rdy;
  logic          gnt;
  logic [DW-1:0] rdata;
  logic          rvalid;

  modport master (
    output req, wr, addr, wdata,
    input  rdy, gnt, rdata, rvalid
  );

  modport slave (
    input  req, wr, addr, wdata,
    output rdy, gnt, rdata, rvalid
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a 256x8 single-port data memory.
// Each port holds one buffered command; one memory access per cycle.
// Optional feature: define DATA_MEM_ARB_RR_EN for round-robin tie breaking;
// without it ties always go to port A.
module data_mem_arbiter (
  input  logic                 Clk,
  input  logic                 Reset,
  data_mem_arbiter_if.slave    port_a,
  data_mem_arbiter_if.slave    port_b,
  output logic                 MemWriteEn,
  output logic [7:0]           MemAddress,
  output logic [7:0]           MemDataIn,
  input  logic [7:0]           MemDataOut
);
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

  logic          pend_a_q,   pend_a_d,   pend_b_q,   pend_b_d;
  cmd_t          cmd_a_q,    cmd_a_d,    cmd_b_q,    cmd_b_d;
  logic [DW-1:0] rdata_a_q,  rdata_a_d,  rdata_b_q,  rdata_b_d;
  logic          rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
  port_e         last_gnt_q, last_gnt_d;

  logic gnt_a_c, gnt_b_c;
  logic rdy_a_c, rdy_b_c;
  logic acc_a_c, acc_b_c;

  // Grant selection from the buffered commands; ties resolved by build option.
  always_comb begin
    gnt_a_c = 1'b0;
    gnt_b_c = 1'b0;
    if (pend_a_q && pend_b_q) begin
`ifdef DATA_MEM_ARB_RR_EN
      if (last_gnt_q == PORT_B) gnt_a_c = 1'b1;
      else                      gnt_b_c = 1'b1;
`else
      gnt_a_c = 1'b1;
`endif
    end else begin
      gnt_a_c = pend_a_q;
      gnt_b_c = pend_b_q;
    end
  end

  // A port may load a new command whenever its buffer is empty or being served.
  always_comb begin
    rdy_a_c = !pend_a_q || gnt_a_c;
    rdy_b_c = !pend_b_q || gnt_b_c;
    acc_a_c = port_a.req && rdy_a_c && !Reset;
    acc_b_c = port_b.req && rdy_b_c && !Reset;
  end

  // Drive the memory from the granted buffer; reset suppresses any write.
  always_comb begin
    MemWriteEn = 1'b0;
    MemAddress = '0;
    MemDataIn  = '0;
    if (gnt_a_c) begin
      MemWriteEn = cmd_a_q.wr && !Reset;
      MemAddress = cmd_a_q.addr;
      MemDataIn  = cmd_a_q.wdata;
    end else if (gnt_b_c) begin
      MemWriteEn = cmd_b_q.wr && !Reset;
      MemAddress = cmd_b_q.addr;
      MemDataIn  = cmd_b_q.wdata;
    end
  end

  // Next-state for buffers, read data, read-valid pulses and last grant.
  always_comb begin
    pend_a_d   = pend_a_q;
    pend_b_d   = pend_b_q;
    cmd_a_d    = cmd_a_q;
    cmd_b_d    = cmd_b_q;
    rdata_a_d  = rdata_a_q;
    rdata_b_d  = rdata_b_q;
    rvalid_a_d = 1'b0;
    rvalid_b_d = 1'b0;
    last_gnt_d = last_gnt_q;

    if (gnt_a_c) begin
      pend_a_d   = 1'b0;
      last_gnt_d = PORT_A;
      if (!cmd_a_q.wr) begin
        rdata_a_d  = MemDataOut;
        rvalid_a_d = 1'b1;
      end
    end
    if (gnt_b_c) begin
      pend_b_d   = 1'b0;
      last_gnt_d = PORT_B;
      if (!cmd_b_q.wr) begin
        rdata_b_d  = MemDataOut;
        rvalid_b_d = 1'b1;
      end
    end

    if (acc_a_c) begin
      pend_a_d = 1'b1;
      cmd_a_d  = '{wr: port_a.wr, addr: port_a.addr, wdata: port_a.wdata};
    end
    if (acc_b_c) begin
      pend_b_d = 1'b1;
      cmd_b_d  = '{wr: port_b.wr, addr: port_b.addr, wdata: port_b.wdata};
    end
  end

  // State registers with synchronous reset; command payloads need no reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pend_a_q   <= 1'b0;
      pend_b_q   <= 1'b0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      last_gnt_q <= PORT_B;
    end else begin
      pend_a_q   <= pend_a_d;
      pend_b_q   <= pend_b_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // Command payload capture.
  always_ff @(posedge Clk) begin
    cmd_a_q <= cmd_a_d;
    cmd_b_q <= cmd_b_d;
  end

  assign port_a.rdy    = rdy_a_c;
  assign port_b.rdy    = rdy_b_c;
  assign port_a.gnt    = gnt_a_c;
  assign port_b.gnt    = gnt_b_c;
  assign port_a.rdata  = rdata_a_q;
  assign port_b.rdata  = rdata_b_q;
  assign port_a.rvalid = rvalid_a_q;
  assign port_b.rvalid = rvalid_b_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model of the two ports.
module tb_data_mem_arbiter;
`ifdef DATA_MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset;
  logic       MemWriteEn;
  logic [7:0] MemAddress, MemDataIn, MemDataOut;

  data_mem_arbiter_if ifa ();
  data_mem_arbiter_if ifb ();

  data_mem_arbiter dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .port_a     (ifa),
    .port_b     (ifb),
    .MemWriteEn (MemWriteEn),
    .MemAddress (MemAddress),
    .MemDataIn  (MemDataIn),
    .MemDataOut (MemDataOut)
  );

  always #5 Clk = ~Clk;

  // External memory seen by the DUT.
  logic [7:0] mem [256];
  assign MemDataOut = mem[MemAddress];
  always @(posedge Clk) if (MemWriteEn) mem[MemAddress] <= MemDataIn;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model: one optional pending command per port, its own memory image.
  bit         m_pend  [2];
  bit         m_wr    [2];
  logic [7:0] m_addr  [2];
  logic [7:0] m_wdata [2];
  logic [7:0] m_rdata [2];
  bit         m_rv    [2];
  int         m_last;
  logic [7:0] m_mem   [256];

  function automatic int pick();
    if (m_pend[0] && m_pend[1]) return RR ? ((m_last == 0) ? 1 : 0) : 0;
    if (m_pend[0]) return 0;
    if (m_pend[1]) return 1;
    return -1;
  endfunction

  function automatic bit in_req(int p);
    return (p == 0) ? ifa.req : ifb.req;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at each active edge.
  always @(posedge Clk) begin
    int w;
    bit rdy [2];
    w = pick();
    for (int p = 0; p < 2; p++) rdy[p] = !m_pend[p] || (w == p);
    if (Reset) begin
      m_pend  = '{1'b0, 1'b0};
      m_rv    = '{1'b0, 1'b0};
      m_rdata = '{8'h00, 8'h00};
      m_last  = 1;
    end else begin
      m_rv = '{1'b0, 1'b0};
      if (w >= 0) begin
        if (m_wr[w]) m_mem[m_addr[w]] = m_wdata[w];
        else begin
          m_rdata[w] = m_mem[m_addr[w]];
          m_rv[w]    = 1'b1;
        end
        m_last    = w;
        m_pend[w] = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        if (in_req(p) && rdy[p]) begin
          m_pend[p]  = 1'b1;
          m_wr[p]    = (p == 0) ? ifa.wr    : ifb.wr;
          m_addr[p]  = (p == 0) ? ifa.addr  : ifb.addr;
          m_wdata[p] = (p == 0) ? ifa.wdata : ifb.wdata;
        end
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge Clk) begin
    int w;
    logic       e_we;
    logic [7:0] e_addr, e_din;
    if (chk_en) begin
      w = pick();
      e_we = 1'b0; e_addr = 8'h00; e_din = 8'h00;
      if (w >= 0) begin
        e_we   = m_wr[w] && !Reset;
        e_addr = m_addr[w];
        e_din  = m_wdata[w];
      end
      chk("gnt_a",    32'(ifa.gnt),    32'(w == 0));
      chk("gnt_b",    32'(ifb.gnt),    32'(w == 1));
      chk("rdy_a",    32'(ifa.rdy),    32'(!m_pend[0] || w == 0));
      chk("rdy_b",    32'(ifb.rdy),    32'(!m_pend[1] || w == 1));
      chk("mem_we",   32'(MemWriteEn), 32'(e_we));
      chk("mem_addr", 32'(MemAddress), 32'(e_addr));
      chk("mem_din",  32'(MemDataIn),  32'(e_din));
      chk("rvalid_a", 32'(ifa.rvalid), 32'(m_rv[0]));
      chk("rvalid_b", 32'(ifb.rvalid), 32'(m_rv[1]));
      chk("rdata_a",  32'(ifa.rdata),  32'(m_rdata[0]));
      chk("rdata_b",  32'(ifb.rdata),  32'(m_rdata[1]));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drv(input bit ra, input bit wa, input logic [7:0] aa, input logic [7:0] da,
                     input bit rb, input bit wb, input logic [7:0] ab, input logic [7:0] db);
    ifa.req = ra; ifa.wr = wa; ifa.addr = aa; ifa.wdata = da;
    ifb.req = rb; ifb.wr = wb; ifb.addr = ab; ifb.wdata = db;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  bit ga [4];
  bit gb [4];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 8'($urandom);
      m_mem[i] = mem[i];
    end
    mem[8'h40]   = 8'h00;
    m_mem[8'h40] = 8'h00;
    Reset = 1'b1;
    idle();
    tick();
    chk_en = 1'b1;
    tick();
    Reset = 1'b0;

    // Write 0x5A to 0x10 from A.
    drv(1'b1, 1'b1, 8'h10, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00);
    tick(); idle();
    @(negedge Clk);
    chk("wr_gnt_a", 32'(ifa.gnt), 32'd1);
    chk("wr_we",    32'(MemWriteEn), 32'd1);
    chk("wr_addr",  32'(MemAddress), 32'h10);
    chk("wr_din",   32'(MemDataIn),  32'h5A);
    tick();
    @(negedge Clk);
    chk("wr_no_rv_a", 32'(ifa.rvalid), 32'd0);

    // B reads it back.
    drv(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    tick(); idle();
    @(negedge Clk);
    chk("rd_gnt_b", 32'(ifb.gnt), 32'd1);
    tick();
    @(negedge Clk);
    chk("rd_rv_b",    32'(ifb.rvalid), 32'd1);
    chk("rd_rdata_b", 32'(ifb.rdata),  32'h5A);

    // Simultaneous write by A and read by B of the same address after reset.
    Reset = 1'b1; tick(); Reset = 1'b0;
    drv(1'b1, 1'b1, 8'h20, 8'h33, 1'b1, 1'b0, 8'h20, 8'h00);
    tick(); idle();
    @(negedge Clk);
    chk("tie_gnt_a", 32'(ifa.gnt), 32'd1);
    chk("tie_gnt_b", 32'(ifb.gnt), 32'd0);
    tick();
    @(negedge Clk);
    chk("tie_gnt_b2", 32'(ifb.gnt), 32'd1);
    tick();
    @(negedge Clk);
    chk("tie_rv_b",    32'(ifb.rvalid), 32'd1);
    chk("tie_rdata_b", 32'(ifb.rdata),  32'h33);

    // A streams reads while B holds one pending read.
    Reset = 1'b1; tick(); Reset = 1'b0;
    drv(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
    tick();
    ifb.req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      ga[k] = ifa.gnt;
      gb[k] = ifb.gnt;
      tick();
    end
    idle();
    if (RR) begin
      chk("stream_g0_a", 32'(ga[0]), 32'd1);
      chk("stream_g1_b", 32'(gb[1]), 32'd1);
      chk("stream_g2_a", 32'(ga[2]), 32'd1);
    end else begin
      for (int k = 0; k < 4; k++) chk("stream_no_b", 32'(gb[k]), 32'd0);
    end
    tick(); tick(); tick();

    // Reset lands while a write to 0x40 is pending.
    Reset = 1'b1; tick(); Reset = 1'b0;
    drv(1'b1, 1'b1, 8'h40, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00);
    tick(); idle();
    Reset = 1'b1;
    @(negedge Clk);
    chk("rst_we", 32'(MemWriteEn), 32'd0);
    tick();
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_rdy_a",  32'(ifa.rdy),    32'd1);
    chk("rst_rv_a",   32'(ifa.rvalid), 32'd0);
    chk("rst_gnt_a",  32'(ifa.gnt),    32'd0);
    chk("rst_mem_40", 32'(mem[8'h40]), 32'h00);

    // Random traffic on a narrow address range to force hazards and ties.
    for (int c = 0; c < 3000; c++) begin
      Reset     = ($urandom_range(0, 79) == 0);
      ifa.req   = ($urandom_range(0, 9) < 6);
      ifa.wr    = 1'($urandom);
      ifa.addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      ifa.wdata = 8'($urandom);
      ifb.req   = ($urandom_range(0, 9) < 6);
      ifb.wr    = 1'($urandom);
      ifb.addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      ifb.wdata = 8'($urandom);
      tick();
    end
    Reset = 1'b0;
    idle();
    tick(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
